// File: rtl/serial_compare_pkg.sv
// Shared definitions for the serial MSB-first comparator: FSM encoding and
// the index/cycle-count width helper.
package serial_compare_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 32;

    // Width of the bit-index down-counter and of the reported cycle count:
    // wide enough to hold the value WIDTH itself.
    function automatic int calc_idx_w(input int width);
        return $clog2(width) + 1;
    endfunction

    localparam int IDX_W = calc_idx_w(DEFAULT_WIDTH);

endpackage

// File: rtl/serial_compare_msb_first_if.sv
// Operand/result handshake bundle for the serial comparator.
interface serial_compare_msb_first_if #(
    parameter int WIDTH = 32
);
    localparam int IDX_W = $clog2(WIDTH) + 1;

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out;
    logic             eq;
    logic             gt;
    logic [IDX_W-1:0] cycles;

    // Producer of operands / consumer of results.
    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, out, eq, gt, cycles
    );

    // The comparator itself.
    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, out, eq, gt, cycles
    );

endinterface

// File: rtl/serial_bit_decide.sv
// Per-bit decision for the MSB-first scan: flags the first differing bit and
// says which operand is smaller when that bit decides the comparison.
module serial_bit_decide (
    input  logic a_bit,
    input  logic b_bit,
    input  logic is_msb,
    input  logic signed_mode,
    input  logic decided,
    output logic differ,
    output logic lt_bit
);

    // A difference only counts if no earlier (more significant) bit decided;
    // at the sign bit the operand holding a 1 is the negative, smaller one.
    always_comb begin
        differ = 1'b0;
        lt_bit = 1'b0;
        if (!decided && (a_bit != b_bit)) begin
            differ = 1'b1;
        end else begin
            differ = 1'b0;
        end
        if (is_msb && signed_mode) begin
            lt_bit = a_bit;
        end else begin
            lt_bit = b_bit;
        end
    end

endmodule

// File: rtl/serial_compare_msb_first.sv
// Multi-cycle set-less-than unit: latches two operands, walks them from the
// MSB down one bit per clock and reports an SLT word plus eq/gt flags and
// the number of bits examined, behind valid/ready handshakes.
module serial_compare_msb_first
    import serial_compare_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter bit SIGNED     = 1'b1,
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic                        clk,
    input  logic                        reset,
    serial_compare_msb_first_if.slave   bus
);

    localparam int             IW        = calc_idx_w(WIDTH);
    localparam logic [IW-1:0]  MSB_IDX   = IW'(WIDTH - 1);
    localparam logic [IW-1:0]  WIDTH_CNT = IW'(WIDTH);
    localparam logic [IW-1:0]  IDX_ZERO  = {IW{1'b0}};
    localparam logic [IW-1:0]  IDX_ONE   = {{(IW-1){1'b0}}, 1'b1};

    state_t            state_r;
    state_t            next_state_s;

    logic [WIDTH-1:0]  a_r;
    logic [WIDTH-1:0]  b_r;
    logic [IW-1:0]     idx_r;
    logic              decided_r;
    logic              lt_r;
    logic [IW-1:0]     scan_cycles_r;

    logic              in_ready_r;
    logic              out_valid_r;
    logic              out_r;
    logic              eq_r;
    logic              gt_r;
    logic [IW-1:0]     cycles_r;

    logic              a_bit_s;
    logic              b_bit_s;
    logic              is_msb_s;
    logic              first_diff_s;
    logic              lt_bit_s;
    logic              scan_last_s;

    assign a_bit_s  = a_r[idx_r[IW-2:0]];
    assign b_bit_s  = b_r[idx_r[IW-2:0]];
    assign is_msb_s = (idx_r == MSB_IDX);

    serial_bit_decide u_bit_decide (
        .a_bit       (a_bit_s),
        .b_bit       (b_bit_s),
        .is_msb      (is_msb_s),
        .signed_mode (SIGNED),
        .decided     (decided_r),
        .differ      (first_diff_s),
        .lt_bit      (lt_bit_s)
    );

    // The scan ends at bit 0, or earlier at the first difference when early exit is on.
    always_comb begin
        scan_last_s = 1'b0;
        if ((EARLY_EXIT && first_diff_s) || (idx_r == IDX_ZERO)) begin
            scan_last_s = 1'b1;
        end else begin
            scan_last_s = 1'b0;
        end
    end

    // Next-state logic for the IDLE -> SCAN -> DONE -> IDLE sequence.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (bus.in_valid) begin
                    next_state_s = SCAN;
                end else begin
                    next_state_s = IDLE;
                end
            end
            SCAN: begin
                if (scan_last_s) begin
                    next_state_s = DONE;
                end else begin
                    next_state_s = SCAN;
                end
            end
            DONE: begin
                if (out_valid_r && bus.out_ready) begin
                    next_state_s = IDLE;
                end else begin
                    next_state_s = DONE;
                end
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Operand capture, bit-index down-counter and running compare result.
    always_ff @(posedge clk) begin
        if (reset) begin
            a_r           <= {WIDTH{1'b0}};
            b_r           <= {WIDTH{1'b0}};
            idx_r         <= IDX_ZERO;
            decided_r     <= 1'b0;
            lt_r          <= 1'b0;
            scan_cycles_r <= IDX_ZERO;
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_r       <= bus.a;
                        b_r       <= bus.b;
                        idx_r     <= MSB_IDX;
                        decided_r <= 1'b0;
                        lt_r      <= 1'b0;
                    end
                end
                SCAN: begin
                    if (first_diff_s) begin
                        decided_r <= 1'b1;
                        lt_r      <= lt_bit_s;
                    end
                    if (scan_last_s) begin
                        scan_cycles_r <= WIDTH_CNT - idx_r;
                    end else begin
                        idx_r <= idx_r - IDX_ONE;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Registered handshake flags and result fields; the fields only change
    // when a new result is published, so they hold across the idle time.
    always_ff @(posedge clk) begin
        if (reset) begin
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            out_r       <= 1'b0;
            eq_r        <= 1'b0;
            gt_r        <= 1'b0;
            cycles_r    <= IDX_ZERO;
        end else begin
            in_ready_r <= (next_state_s == IDLE);
            if ((state_r == DONE) && !out_valid_r) begin
                out_valid_r <= 1'b1;
                out_r       <= lt_r;
                eq_r        <= !decided_r;
                gt_r        <= decided_r && !lt_r;
                cycles_r    <= scan_cycles_r;
            end else if (out_valid_r && bus.out_ready) begin
                out_valid_r <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.out       = {{(WIDTH-1){1'b0}}, out_r};
    assign bus.eq        = eq_r;
    assign bus.gt        = gt_r;
    assign bus.cycles    = cycles_r;

endmodule

// File: tb/tb_serial_compare_msb_first.sv
// Bench for serial_compare_msb_first: four instances cover every
// SIGNED/EARLY_EXIT combination and share one stimulus stream; results are
// compared with an arithmetic reference model.
module tb_serial_compare_msb_first;

    localparam int W    = 32;
    localparam int NCFG = 4;
    localparam int CW   = $clog2(W) + 1;

    logic clk = 1'b0;
    logic reset;
    logic in_valid;
    logic out_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;

    logic [NCFG-1:0]         ir;
    logic [NCFG-1:0]         ov;
    logic [NCFG-1:0]         eqv;
    logic [NCFG-1:0]         gtv;
    logic [NCFG-1:0][W-1:0]  outv;
    logic [NCFG-1:0][CW-1:0] cycv;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // Config g: SIGNED when g is even, EARLY_EXIT when g < 2.
    for (genvar g = 0; g < NCFG; g++) begin : g_dut
        localparam bit S = ((g % 2) == 0);
        localparam bit E = (g < 2);
        serial_compare_msb_first_if #(.WIDTH(W)) bus ();
        assign bus.in_valid  = in_valid;
        assign bus.a         = a;
        assign bus.b         = b;
        assign bus.out_ready = out_ready;
        assign ir[g]   = bus.in_ready;
        assign ov[g]   = bus.out_valid;
        assign eqv[g]  = bus.eq;
        assign gtv[g]  = bus.gt;
        assign outv[g] = bus.out;
        assign cycv[g] = bus.cycles;
        serial_compare_msb_first #(.WIDTH(W), .SIGNED(S), .EARLY_EXIT(E)) dut (
            .clk   (clk),
            .reset (reset),
            .bus   (bus)
        );
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference: plain arithmetic compare; cycles = bits examined.
    function automatic void model(input int g, input logic [W-1:0] x, input logic [W-1:0] y,
                                  output logic lt, output logic eq, output logic gt, output int cyc);
        logic         s;
        logic         ee;
        logic [W-1:0] d;
        int           hi;
        s  = ((g % 2) == 0);
        ee = (g < 2);
        if (s) lt = ($signed(x) < $signed(y));
        else   lt = (x < y);
        eq = (x == y);
        gt = !lt && !eq;
        d  = x ^ y;
        hi = -1;
        for (int p = 0; p < W; p++) begin
            if (d[p]) hi = p;
        end
        cyc = (ee && hi >= 0) ? (W - hi) : W;
    endfunction

    task automatic check_fields(input logic [W-1:0] x, input logic [W-1:0] y, input string pfx);
        logic lt, eq, gt;
        int   cyc;
        for (int g = 0; g < NCFG; g++) begin
            model(g, x, y, lt, eq, gt, cyc);
            check($sformatf("%s cfg%0d out", pfx, g), 64'(outv[g]), {63'd0, lt});
            check($sformatf("%s cfg%0d eq", pfx, g), 64'(eqv[g]), {63'd0, eq});
            check($sformatf("%s cfg%0d gt", pfx, g), 64'(gtv[g]), {63'd0, gt});
            check($sformatf("%s cfg%0d cycles", pfx, g), 64'(cycv[g]), 64'(cyc));
        end
    endtask

    task automatic send(input logic [W-1:0] x, input logic [W-1:0] y);
        @(negedge clk);
        a = x;
        b = y;
        in_valid = 1'b1;
        check("in_ready before accept", 64'(ir), 64'({NCFG{1'b1}}));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = $urandom;
        b = $urandom;
    endtask

    // Called just after the accept edge; counts edges until each out_valid.
    task automatic wait_results(input logic [W-1:0] x, input logic [W-1:0] y);
        int   lat [NCFG];
        logic lt, eq, gt;
        int   cyc;
        logic all_done;
        for (int g = 0; g < NCFG; g++) lat[g] = 0;
        for (int n = 1; n <= W + 8; n++) begin
            @(posedge clk);
            #1;
            all_done = 1'b1;
            for (int g = 0; g < NCFG; g++) begin
                if (ov[g] && lat[g] == 0) lat[g] = n;
                if (lat[g] == 0) all_done = 1'b0;
            end
            if (all_done) break;
        end
        for (int g = 0; g < NCFG; g++) begin
            model(g, x, y, lt, eq, gt, cyc);
            check($sformatf("cfg%0d latency a=%h b=%h", g, x, y), 64'(lat[g]), 64'(cyc + 1));
        end
        check("in_ready while busy", 64'(ir), 64'd0);
        check_fields(x, y, "result");
    endtask

    task automatic drain();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("out_valid after handoff", 64'(ov), 64'd0);
        check("in_ready after handoff", 64'(ir), 64'({NCFG{1'b1}}));
    endtask

    task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y);
        send(x, y);
        wait_results(x, y);
        drain();
    endtask

    task automatic check_reset_state(input string pfx);
        check($sformatf("%s in_ready", pfx), 64'(ir), 64'({NCFG{1'b1}}));
        check($sformatf("%s out_valid", pfx), 64'(ov), 64'd0);
        check($sformatf("%s eq", pfx), 64'(eqv), 64'd0);
        check($sformatf("%s gt", pfx), 64'(gtv), 64'd0);
        for (int g = 0; g < NCFG; g++) begin
            check($sformatf("%s cfg%0d out", pfx, g), 64'(outv[g]), 64'd0);
            check($sformatf("%s cfg%0d cycles", pfx, g), 64'(cycv[g]), 64'd0);
        end
    endtask

    initial begin
        logic [W-1:0] x;
        logic [W-1:0] y;
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_state("reset");
        reset = 1'b0;

        // Directed operand pairs: sign boundary, equality, LSB-only difference.
        run_op(32'hFFFF_FFFF, 32'h0000_0001);
        run_op(32'h1234_5678, 32'h1234_5678);
        run_op(32'h0000_0006, 32'h0000_0007);
        run_op(32'h8000_0000, 32'h7FFF_FFFF);
        run_op(32'h0000_0000, 32'h0000_0000);

        // Random pairs, biased toward equal and single-bit-difference cases.
        for (int i = 0; i < 24; i++) begin
            x = $urandom;
            case ($urandom_range(0, 2))
                0:       y = $urandom;
                1:       y = x;
                default: y = x ^ (32'h1 << $urandom_range(0, W - 1));
            endcase
            run_op(x, y);
        end

        // Back-pressure: result must hold while out_ready stays low.
        x = $urandom;
        y = x ^ 32'h0001_0000;
        send(x, y);
        wait_results(x, y);
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            check("hold out_valid", 64'(ov), 64'({NCFG{1'b1}}));
            check("hold in_ready", 64'(ir), 64'd0);
            check_fields(x, y, "hold");
        end
        // Handoff with a waiting operand: the accept must land one cycle later.
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        a = y;
        b = x;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("handoff out_valid", 64'(ov), 64'd0);
        check("handoff in_ready", 64'(ir), 64'({NCFG{1'b1}}));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("re-accept in_ready", 64'(ir), 64'd0);
        wait_results(y, x);
        drain();

        // Reset in the middle of a scan discards the operation.
        send(32'd5, 32'd7);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check_reset_state("mid-scan reset");
        run_op(32'd5, 32'd7);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
